// File: rtl/regfile_wr_arbiter_if.sv
// Write-request bundle between the requesters, the write arbiter and the register file write ports.
// Handshake: a write transfers when req_valid_i & req_ready_o are both high; a requester holds valid/addr/data until ready.
interface regfile_wr_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2
);
  logic [NR_REQ-1:0]                         req_valid_i;
  logic [NR_REQ-1:0]                         req_ready_o;
  logic [NR_REQ-1:0][4:0]                    req_addr_i;
  logic [NR_REQ-1:0][DATA_WIDTH-1:0]         req_data_i;
  logic [NR_WRITE_PORTS-1:0][4:0]            waddr_o;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_o;
  logic [NR_WRITE_PORTS-1:0]                 we_o;
  logic                                      init_done_o;
  logic                                      dbg_run_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, waddr_o, wdata_o, we_o, init_done_o, dbg_run_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, waddr_o, wdata_o, we_o, init_done_o, dbg_run_o
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write ports among several writers,
// with a post-reset sequencer that zeroes all 32 registers before serving requests.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter bit ZERO_REG_ZERO  = 1'b0,
  parameter bit INIT_ON_RESET  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int RR_W = $clog2(NR_REQ);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} fsm_e;

  fsm_e                                      fsm_q, fsm_d;
  logic [5:0]                                init_cnt_q, init_cnt_d;
  logic [RR_W-1:0]                           rr_ptr_q, rr_ptr_d;
  logic [NR_REQ-1:0]                         ready_d;
  logic [NR_WRITE_PORTS-1:0][4:0]            waddr_d;
  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_d;
  logic [NR_WRITE_PORTS-1:0]                 we_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q      <= INIT_ON_RESET ? INIT : RUN;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      fsm_q      <= fsm_d;
      init_cnt_q <= init_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin : arb
    logic [6:0]      init_addr;
    logic [RR_W-1:0] idx;
    logic [RR_W-1:0] last;
    logic            conflict;
    logic            any;
    int              slot;

    fsm_d      = fsm_q;
    init_cnt_d = init_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    ready_d    = '0;
    waddr_d    = '0;
    wdata_d    = '0;
    we_d       = '0;
    init_addr  = '0;
    idx        = '0;
    last       = rr_ptr_q;
    conflict   = 1'b0;
    any        = 1'b0;
    slot       = 0;

    case (fsm_q)
      INIT: begin
        // Slots past register 31 in the final init beat stay disabled.
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          init_addr  = {1'b0, init_cnt_q} + 7'(p);
          waddr_d[p] = init_addr[4:0];
          we_d[p]    = (init_addr < 7'd32);
        end
        init_cnt_d = init_cnt_q + 6'(NR_WRITE_PORTS);
        if (({1'b0, init_cnt_q} + 7'(NR_WRITE_PORTS)) >= 7'd32) fsm_d = RUN;
      end
      RUN: begin
        for (int k = 0; k < NR_REQ; k++) begin
          idx      = RR_W'((int'(rr_ptr_q) + k) % NR_REQ);
          conflict = 1'b0;
          // A same-address loser is skipped; the scan continues past it.
          for (int q = 0; q < NR_WRITE_PORTS; q++) begin
            if (q < slot && waddr_d[q] == bus.req_addr_i[idx]) conflict = 1'b1;
          end
          if (bus.req_valid_i[idx] && !conflict && slot < NR_WRITE_PORTS) begin
            for (int q = 0; q < NR_WRITE_PORTS; q++) begin
              if (q == slot) begin
                waddr_d[q] = bus.req_addr_i[idx];
                wdata_d[q] = bus.req_data_i[idx];
                we_d[q]    = !(ZERO_REG_ZERO && bus.req_addr_i[idx] == 5'd0);
              end
            end
            ready_d[idx] = 1'b1;
            last         = idx;
            any          = 1'b1;
            slot         = slot + 1;
          end
        end
        if (any) rr_ptr_d = RR_W'((int'(last) + 1) % NR_REQ);
      end
      default: fsm_d = INIT;
    endcase
  end

  // Reset gates the strobes combinationally so nothing is written or acknowledged while it is held.
  assign bus.req_ready_o = rst_ni ? ready_d : '0;
  assign bus.we_o        = rst_ni ? we_d : '0;
  assign bus.waddr_o     = waddr_d;
  assign bus.wdata_o     = wdata_d;
  assign bus.init_done_o = rst_ni && (fsm_q == RUN);
  assign bus.dbg_run_o   = (fsm_q == RUN);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: two instances (x0 kept writable / x0 dropped) share one stimulus
// and are checked every cycle against a rule-level model plus a bench-side register file.
module tb_regfile_wr_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int NWP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NWP)) bus ();
  regfile_wr_arbiter_if #(.DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NWP)) bus_z ();

  logic [NR-1:0]         r_valid;
  logic [NR-1:0][4:0]    r_addr;
  logic [NR-1:0][DW-1:0] r_data;

  assign bus.req_valid_i   = r_valid;
  assign bus.req_addr_i    = r_addr;
  assign bus.req_data_i    = r_data;
  assign bus_z.req_valid_i = r_valid;
  assign bus_z.req_addr_i  = r_addr;
  assign bus_z.req_data_i  = r_data;

  regfile_wr_arbiter #(
    .DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NWP),
    .ZERO_REG_ZERO(1'b0), .INIT_ON_RESET(1'b1)
  ) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  regfile_wr_arbiter #(
    .DATA_WIDTH(DW), .NR_REQ(NR), .NR_WRITE_PORTS(NWP),
    .ZERO_REG_ZERO(1'b1), .INIT_ON_RESET(1'b1)
  ) u_dut_z (.clk_i(clk), .rst_ni(rst_n), .bus(bus_z));

  // Register files fed by each arbiter, used for readback.
  logic [DW-1:0] rf0 [32];
  logic [DW-1:0] rf1 [32];
  always @(posedge clk) begin
    for (int p = 0; p < NWP; p++) begin
      if (bus.we_o[p])   rf0[bus.waddr_o[p]]   <= bus.wdata_o[p];
      if (bus_z.we_o[p]) rf1[bus_z.waddr_o[p]] <= bus_z.wdata_o[p];
    end
  end

  // Model state
  bit            m_init = 1'b1;
  int            m_cyc  = 0;
  int            m_rr   = 0;
  logic [DW-1:0] m_rf0 [32];
  logic [DW-1:0] m_rf1 [32];

  logic [NR-1:0]          e_ready;
  logic [NWP-1:0][4:0]    e_waddr;
  logic [NWP-1:0][DW-1:0] e_wdata;
  logic [NWP-1:0]         e_we0, e_we1;
  logic                   e_done;
  bit                     e_any;
  int                     e_last;
  logic [NR-1:0]          last_grant;

  logic [NR-1:0]       g_ready;
  logic [NWP-1:0][4:0] g_waddr;
  logic                g_done;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  int            wait_c [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void predict();
    bit used [32];
    int slot;
    int a;
    int i;
    e_ready = '0; e_waddr = '0; e_wdata = '0; e_we0 = '0; e_we1 = '0;
    e_any = 1'b0; e_last = 0;
    e_done = rst_n && !m_init;
    if (!rst_n) return;
    if (m_init) begin
      for (int p = 0; p < NWP; p++) begin
        a = m_cyc * NWP + p;
        e_waddr[p] = 5'(a);
        e_we0[p]   = (a < 32);
        e_we1[p]   = (a < 32);
      end
    end else begin
      for (int r = 0; r < 32; r++) used[r] = 1'b0;
      slot = 0;
      for (int k = 0; k < NR; k++) begin
        i = (m_rr + k) % NR;
        if (slot < NWP && r_valid[i] && !used[r_addr[i]]) begin
          used[r_addr[i]] = 1'b1;
          e_ready[i]      = 1'b1;
          e_waddr[slot]   = r_addr[i];
          e_wdata[slot]   = r_data[i];
          e_we0[slot]     = 1'b1;
          e_we1[slot]     = (r_addr[i] != 5'd0);
          e_any           = 1'b1;
          e_last          = i;
          slot++;
        end
      end
    end
  endfunction

  task automatic step();
    @(negedge clk);
    predict();
    g_ready = bus.req_ready_o;
    g_waddr = bus.waddr_o;
    g_done  = bus.init_done_o;
    check("init_done", 64'(bus.init_done_o), 64'(e_done));
    check("ready", 64'(bus.req_ready_o), 64'(e_ready));
    check("we", 64'(bus.we_o), 64'(e_we0));
    check("z_init_done", 64'(bus_z.init_done_o), 64'(e_done));
    check("z_ready", 64'(bus_z.req_ready_o), 64'(e_ready));
    check("z_we", 64'(bus_z.we_o), 64'(e_we1));
    if (rst_n) begin
      check("waddr", 64'(bus.waddr_o), 64'(e_waddr));
      check("wdata", 64'(bus.wdata_o), 64'(e_wdata));
      check("z_waddr", 64'(bus_z.waddr_o), 64'(e_waddr));
      check("z_wdata", 64'(bus_z.wdata_o), 64'(e_wdata));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_init = 1'b1; m_cyc = 0; m_rr = 0;
    end else if (m_init) begin
      for (int p = 0; p < NWP; p++) begin
        if (e_we0[p]) begin
          m_rf0[e_waddr[p]] = '0;
          m_rf1[e_waddr[p]] = '0;
        end
      end
      m_cyc++;
      if (m_cyc * NWP >= 32) m_init = 1'b0;
    end else begin
      for (int p = 0; p < NWP; p++) begin
        if (e_we0[p]) m_rf0[e_waddr[p]] = e_wdata[p];
        if (e_we1[p]) m_rf1[e_waddr[p]] = e_wdata[p];
      end
      if (e_any) m_rr = (e_last + 1) % NR;
    end
    last_grant = e_ready;
    #1;
  endtask

  task automatic new_req(input int i, input int lo, input int hi);
    r_valid[i] = 1'b1;
    r_addr[i]  = 5'($urandom_range(lo, hi));
    r_data[i]  = $urandom;
  endtask

  // mode 0: granted writers drop; 1: random traffic; 2: granted writers re-request at once
  task automatic cycle(input int mode);
    step();
    for (int i = 0; i < NR; i++) begin
      if (r_valid[i] && last_grant[i]) begin
        if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
          if (mode == 2) r_data[i] = $urandom;
          else new_req(i, 0, 7);
        end else begin
          r_valid[i] = 1'b0;
        end
      end else if (!r_valid[i] && mode == 1 && $urandom_range(0, 2) == 0) begin
        new_req(i, 0, 7);
      end
    end
  endtask

  initial begin
    r_valid = '0; r_addr = '0; r_data = '0; last_grant = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // Init sweep: 16 zeroing beats, then served
    repeat (16) begin
      cycle(0);
      check("init_not_done", 64'(g_done), 64'd0);
    end
    cycle(0);
    check("init_done_cycle17", 64'(g_done), 64'd1);

    // Four writers, distinct addresses
    for (int i = 0; i < NR; i++) begin
      r_valid[i] = 1'b1; r_addr[i] = 5'(5 + i);
    end
    r_data[0] = 32'hAAAA_0001; r_data[1] = 32'hBBBB_0002;
    r_data[2] = 32'hCCCC_0003; r_data[3] = 32'hDDDD_0004;
    cycle(0);
    check("burst_g1", 64'(g_ready), 64'b0011);
    cycle(0);
    check("burst_g2", 64'(g_ready), 64'b1100);
    cycle(0);
    exp_q.push_back(32'hAAAA_0001); exp_q.push_back(32'hBBBB_0002);
    exp_q.push_back(32'hCCCC_0003); exp_q.push_back(32'hDDDD_0004);
    for (int r = 5; r < 9; r++) check("burst_rd", 64'(rf0[r]), 64'(exp_q.pop_front()));

    // Same-address conflict: req1 loses to req0 and is retried
    r_valid = 4'b0111;
    r_addr[0] = 5'd9; r_addr[1] = 5'd9; r_addr[2] = 5'd3;
    r_data[0] = 32'h1111_0000; r_data[1] = 32'h2222_0000; r_data[2] = 32'h3333_0000;
    cycle(0);
    check("conf_g1", 64'(g_ready), 64'b0101);
    cycle(0);
    check("conf_g2", 64'(g_ready), 64'b0010);
    cycle(0);
    check("conf_rd9", 64'(rf0[9]), 64'h2222_0000);
    check("conf_rd3", 64'(rf0[3]), 64'h3333_0000);

    // Write to x0: stored on one instance, dropped on the other
    r_valid = 4'b0001; r_addr[0] = 5'd0; r_data[0] = 32'h0000_DEAD;
    cycle(0);
    check("x0_ack", 64'(g_ready[0]), 64'd1);
    cycle(0);
    check("x0_kept", 64'(rf0[0]), 64'h0000_DEAD);
    check("x0_dropped", 64'(rf1[0]), 64'd0);

    // Reset at init beat 7 restarts the sweep from register 0
    rst_n = 1'b0; cycle(0); rst_n = 1'b1;
    repeat (7) cycle(0);
    rst_n = 1'b0; cycle(0); rst_n = 1'b1;
    cycle(0);
    check("reinit_addr", 64'(g_waddr), 64'({5'd1, 5'd0}));
    repeat (15) cycle(0);

    // Reset in RUN with writes pending; they wait through init, then win from rr_ptr 0
    for (int i = 0; i < NR; i++) new_req(i, 12 + i, 12 + i);
    rst_n = 1'b0; cycle(0);
    check("rst_ready", 64'(g_ready), 64'd0);
    rst_n = 1'b1;
    repeat (16) cycle(0);
    cycle(0);
    check("post_rst_g", 64'(g_ready), 64'b0011);
    repeat (2) cycle(0);

    // Random traffic with a narrow address range for frequent conflicts
    repeat (400) cycle(1);
    for (int n = 0; n < 20 && r_valid != '0; n++) cycle(0);
    check("drained", 64'(r_valid), 64'd0);

    // Fairness: everyone continuously valid on distinct addresses
    for (int i = 0; i < NR; i++) begin
      new_req(i, 20 + i, 20 + i);
      wait_c[i] = 0;
    end
    repeat (12) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (g_ready[i]) begin
          check("fair_wait", 64'(wait_c[i] <= 1), 64'd1);
          wait_c[i] = 0;
          r_data[i] = $urandom;
        end else begin
          wait_c[i]++;
        end
      end
    end
    r_valid = '0;
    repeat (2) cycle(0);

    // Full readback of both register files
    for (int r = 0; r < 32; r++) begin
      exp_q.push_back(m_rf0[r]);
      check("rf0_final", 64'(rf0[r]), 64'(exp_q.pop_front()));
      exp_q.push_back(m_rf1[r]);
      check("rf1_final", 64'(rf1[r]), 64'(exp_q.pop_front()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the integer register file's NR_WRITE_PORTS write ports among NR_REQ independent writers, such as commit ports, a load-writeback path and a debug module. Arbitration is round-robin, and no two writes in the same cycle may target the same address. After reset, an init sequencer zeroes all 32 registers before any requester is served. The block sits directly in front of the register file's waddr_i, wdata_i and we_i inputs; read ports are not touched.

Parameters:
DATA_WIDTH, 32, register width in bits
NR_REQ, 4, number of write requesters (>=2)
NR_WRITE_PORTS, 2, number of register file write ports (1..NR_REQ)
ZERO_REG_ZERO, 0, if 1, writes to x0 are accepted but dropped (we_o low on that slot)
INIT_ON_RESET, 1, if 1, zero all 32 registers after reset before serving requests

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_ni  in  1  synchronous, active-low reset
req_valid_i  in  NR_REQ  requester i has a write pending
req_ready_o  out  NR_REQ  requester i's write is granted this cycle
req_addr_i  in  NR_REQ x 5  destination register
req_data_i  in  NR_REQ x DATA_WIDTH  write data
waddr_o  out  NR_WRITE_PORTS x 5  to register file waddr_i
wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  to register file wdata_i
we_o  out  NR_WRITE_PORTS  to register file we_i
init_done_o  out  1  high once the init sequence has finished and requests are served

Behaviour:
- State: fsm {INIT, RUN}, init_cnt [5:0], rr_ptr [$clog2(NR_REQ)-1:0].
- Reset, sampled while rst_ni=0 at a rising edge:
  - fsm <= INIT if INIT_ON_RESET, else RUN; init_cnt <= 0; rr_ptr <= 0.
- While rst_ni=0, outputs are gated combinationally: we_o=0, req_ready_o=0, init_done_o=0.
- Reset mid-INIT or mid-RUN restarts as above. A request that was not granted is simply retried.
- INIT state:
  - Slot p drives waddr_o[p]=init_cnt+p, wdata_o[p]=0, and we_o[p]=1 iff init_cnt+p<32.
  - init_cnt += NR_WRITE_PORTS each cycle.
  - When init_cnt+NR_WRITE_PORTS>=32: fsm <= RUN.
  - Duration is ceil(32/NR_WRITE_PORTS) cycles (16 for the defaults).
  - req_ready_o=0 and init_done_o=0 throughout.
- RUN state: init_done_o=1. Grant selection is combinational each cycle:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... modulo NR_REQ.
  - A requester is eligible if req_valid_i=1 and its addr differs from every address already granted this cycle.
  - Eligible requesters fill slots 0,1,... in scan order until NR_WRITE_PORTS slots are used.
  - Slot p carries the granted requester's addr and data. we_o[p]=1, except we_o[p]=0 when ZERO_REG_ZERO=1 and addr=0; that write is still acknowledged and still uses the slot.
  - Unused slots: we_o=0, waddr_o=0, wdata_o=0.
  - req_ready_o[i]=1 iff requester i was granted.
- Handshake:
  - A transfer occurs when valid&ready are both high.
  - A requester must hold valid, addr and data stable until ready.
  - ready may depend combinationally on valid, with no combinational path from ready back to valid.
- Latency: zero cycles through the arbiter; the data is readable from the register file the cycle after grant.
- Address conflicts: a same-address loser is skipped and the scan continues past it. It is retried in a later cycle, so at most one write per address per cycle.
- rr_ptr update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NR_REQ.
  - If no grants: unchanged.
  - Each continuously valid requester is granted within ceil(NR_REQ/NR_WRITE_PORTS) RUN cycles.

Test Plan:
- Reset 2 cycles, then idle -> we_o=2'b11 for exactly 16 cycles; addresses (0,1),(2,3)...(30,31) with data 0; init_done_o rises on cycle 17; all req_ready_o stay 0 before it.
- After init, all 4 requesters valid with addrs 5,6,7,8 and data A..D -> cycle 1 grants req0,req1 (ports 0/1 = 5/A, 6/B); cycle 2 grants req2,req3; readback via regfile reads gives A..D.
- req0 and req1 both target addr 9, req2 targets addr 3, rr_ptr=0 -> grants req0 (port 0) and req2 (port 1); req1 ready=0 and is granted in the next cycle.
- ZERO_REG_ZERO=1, req0 writes x0=0xDEAD -> ready_o[0]=1, we_o[0]=0, x0 reads 0; with ZERO_REG_ZERO=0 the same write stores 0xDEAD.
- rst_ni pulled low at init cycle 7 and in RUN with grants pending -> in the reset cycle we_o=0 and ready=0; init restarts at address 0 and rr_ptr=0.
- Fairness: req3 held valid while req0..2 are continuously valid for 10 cycles -> req3 is granted at least every 2 cycles; no requester waits more than 2 cycles.
